// File: rtl/pe_network_interface_if.sv
// Router-facing link of the PE network interface: injection toward the
// router with valid/ready, ejection from the router with valid only.
interface pe_network_interface_if #(
    parameter int COORD_BITS = 1,
    parameter int DATA_WIDTH = 32
);
    localparam int PKT_W = 2 * COORD_BITS + DATA_WIDTH;

    logic [PKT_W-1:0] pe_out_packet;
    logic             pe_out_valid;
    logic             pe_out_ready;
    logic [PKT_W-1:0] pe_in_packet;
    logic             pe_in_valid;

    modport master (
        output pe_out_packet,
        output pe_out_valid,
        input  pe_out_ready,
        input  pe_in_packet,
        input  pe_in_valid
    );

    modport slave (
        input  pe_out_packet,
        input  pe_out_valid,
        output pe_out_ready,
        output pe_in_packet,
        output pe_in_valid
    );
endinterface

// File: rtl/pe_network_interface.sv
// PE network interface: tags CPU words with a destination and queues them
// toward the router; queues router words back to the CPU once armed.
module pe_network_interface #(
    parameter int COORD_BITS = 1,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COORD_BITS-1:0] x_coord_in,
    input  logic                  x_coord_valid,
    input  logic [COORD_BITS-1:0] y_coord_in,
    input  logic                  y_coord_valid,
    input  logic [DATA_WIDTH-1:0] cpu_msg_in,
    input  logic                  cpu_msg_valid,
    input  logic                  packet_complete,
    pe_network_interface_if.master noc,
    output logic [DATA_WIDTH-1:0] cpu_msg_out,
    output logic                  cpu_msg_avail,
    input  logic                  cpu_msg_read,
    input  logic                  cpu_rx_ready,
    output logic                  tx_full,
    output logic                  tx_dropped,
    output logic                  rx_dropped
);
    localparam int PKT_W = 2 * COORD_BITS + DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, ARMED} tx_state_t;

    tx_state_t             state;
    logic [COORD_BITS-1:0] dest_x;
    logic [COORD_BITS-1:0] dest_y;
    logic                  x_set;
    logic                  y_set;

    logic [PKT_W-1:0]      tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      tx_wr;
    logic [PTR_W-1:0]      tx_rd;
    logic [CNT_W-1:0]      tx_cnt;
    logic                  tx_push;
    logic                  tx_pop;

    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rx_wr;
    logic [PTR_W-1:0]      rx_rd;
    logic [CNT_W-1:0]      rx_cnt;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_armed;

    logic                  unused_in_hdr;

    assign unused_in_hdr = ^noc.pe_in_packet[PKT_W-1:DATA_WIDTH];

    // A full FIFO still accepts a push when its head leaves in the same cycle
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_pop   = (tx_cnt != '0) && noc.pe_out_ready;
    assign tx_push  = cpu_msg_valid && (state == ARMED) && (!tx_full || tx_pop);

    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_pop   = (rx_cnt != '0) && cpu_msg_read;
    assign rx_push  = noc.pe_in_valid && rx_armed && (!rx_full || rx_pop);

    assign noc.pe_out_valid  = (tx_cnt != '0);
    assign noc.pe_out_packet = (tx_cnt != '0) ? tx_mem[tx_rd] : '0;
    assign cpu_msg_avail     = (rx_cnt != '0);
    assign cpu_msg_out       = (rx_cnt != '0) ? rx_mem[rx_rd] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            dest_x     <= '0;
            dest_y     <= '0;
            x_set      <= 1'b0;
            y_set      <= 1'b0;
            tx_dropped <= 1'b0;
        end else begin
            if (x_coord_valid) dest_x <= x_coord_in;
            if (y_coord_valid) dest_y <= y_coord_in;
            x_set <= x_set | x_coord_valid;
            y_set <= y_set | y_coord_valid;
            unique case (state)
                IDLE: begin
                    if (x_set && y_set) state <= ARMED;
                end
                ARMED: begin
                    // A coordinate written with the end pulse starts the next packet
                    if (packet_complete) begin
                        state <= IDLE;
                        x_set <= x_coord_valid;
                        y_set <= y_coord_valid;
                    end
                end
            endcase
            if (cpu_msg_valid && !tx_push) tx_dropped <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= {dest_x, dest_y, cpu_msg_in};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_armed   <= 1'b0;
            rx_dropped <= 1'b0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            rx_cnt     <= '0;
        end else begin
            if (cpu_rx_ready) rx_armed <= 1'b1;
            if (noc.pe_in_valid && !rx_push) rx_dropped <= 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= noc.pe_in_packet[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_pe_network_interface.sv
// Scoreboard bench for pe_network_interface: expected TX packets and RX
// words are queued at stimulus time and compared as the DUT emits them.
module tb_pe_network_interface;
    localparam int CB = 1;
    localparam int DW = 32;
    localparam int PW = 2 * CB + DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CB-1:0] x_coord_in = '0;
    logic          x_coord_valid = 1'b0;
    logic [CB-1:0] y_coord_in = '0;
    logic          y_coord_valid = 1'b0;
    logic [DW-1:0] cpu_msg_in = '0;
    logic          cpu_msg_valid = 1'b0;
    logic          packet_complete = 1'b0;
    logic [DW-1:0] cpu_msg_out;
    logic          cpu_msg_avail;
    logic          cpu_msg_read = 1'b0;
    logic          cpu_rx_ready = 1'b0;
    logic          tx_full;
    logic          tx_dropped;
    logic          rx_dropped;

    logic [PW-1:0] tx_q [$];
    logic [DW-1:0] rx_q [$];
    logic [CB-1:0] exp_x = '0;
    logic [CB-1:0] exp_y = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_network_interface_if #(.COORD_BITS(CB), .DATA_WIDTH(DW)) noc ();

    pe_network_interface #(
        .COORD_BITS(CB),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .x_coord_in     (x_coord_in),
        .x_coord_valid  (x_coord_valid),
        .y_coord_in     (y_coord_in),
        .y_coord_valid  (y_coord_valid),
        .cpu_msg_in     (cpu_msg_in),
        .cpu_msg_valid  (cpu_msg_valid),
        .packet_complete(packet_complete),
        .noc            (noc.master),
        .cpu_msg_out    (cpu_msg_out),
        .cpu_msg_avail  (cpu_msg_avail),
        .cpu_msg_read   (cpu_msg_read),
        .cpu_rx_ready   (cpu_rx_ready),
        .tx_full        (tx_full),
        .tx_dropped     (tx_dropped),
        .rx_dropped     (rx_dropped)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && noc.pe_out_valid && noc.pe_out_ready) begin
            if (tx_q.size() == 0)
                check("tx_unexpected", 64'(noc.pe_out_valid), 64'd0);
            else
                check("tx_pkt", 64'(noc.pe_out_packet), 64'(tx_q.pop_front()));
        end
        if (reset_n && cpu_msg_avail && cpu_msg_read) begin
            if (rx_q.size() == 0)
                check("rx_unexpected", 64'(cpu_msg_avail), 64'd0);
            else
                check("rx_msg", 64'(cpu_msg_out), 64'(rx_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_out_valid"}, 64'(noc.pe_out_valid), 64'd0);
        check({pre, "_out_packet"}, 64'(noc.pe_out_packet), 64'd0);
        check({pre, "_avail"}, 64'(cpu_msg_avail), 64'd0);
        check({pre, "_msg_out"}, 64'(cpu_msg_out), 64'd0);
        check({pre, "_tx_full"}, 64'(tx_full), 64'd0);
        check({pre, "_tx_drop"}, 64'(tx_dropped), 64'd0);
        check({pre, "_rx_drop"}, 64'(rx_dropped), 64'd0);
    endtask

    task automatic do_reset();
        x_coord_valid   = 1'b0;
        y_coord_valid   = 1'b0;
        cpu_msg_valid   = 1'b0;
        packet_complete = 1'b0;
        cpu_msg_read    = 1'b0;
        cpu_rx_ready    = 1'b0;
        noc.pe_in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        tx_q.delete();
        rx_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("rst");
        step();
    endtask

    task automatic set_dest(input logic [CB-1:0] x, input logic [CB-1:0] y);
        x_coord_in    = x;
        y_coord_in    = y;
        x_coord_valid = 1'b1;
        y_coord_valid = 1'b1;
        exp_x = x;
        exp_y = y;
        step();
        x_coord_valid = 1'b0;
        y_coord_valid = 1'b0;
        step();
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit ok);
        cpu_msg_in    = d;
        cpu_msg_valid = 1'b1;
        if (ok) tx_q.push_back({exp_x, exp_y, d});
        step();
        cpu_msg_valid = 1'b0;
    endtask

    task automatic end_packet();
        packet_complete = 1'b1;
        step();
        packet_complete = 1'b0;
    endtask

    task automatic arm_rx();
        cpu_rx_ready = 1'b1;
        step();
        cpu_rx_ready = 1'b0;
    endtask

    task automatic send_rx(input logic [DW-1:0] d, input bit ok);
        noc.pe_in_packet = {2'b11, d};
        noc.pe_in_valid  = 1'b1;
        if (ok) rx_q.push_back(d);
        step();
        noc.pe_in_valid = 1'b0;
    endtask

    task automatic drain_tx();
        noc.pe_out_ready = 1'b1;
        for (int i = 0; i < 20 && tx_q.size() != 0; i++) step();
        check("tx_drain_left", 64'(tx_q.size()), 64'd0);
    endtask

    task automatic drain_rx();
        cpu_msg_read = 1'b1;
        for (int i = 0; i < 20 && rx_q.size() != 0; i++) step();
        cpu_msg_read = 1'b0;
        check("rx_drain_left", 64'(rx_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        noc.pe_out_ready = 1'b0;
        noc.pe_in_packet = '0;
        noc.pe_in_valid  = 1'b0;
        do_reset();

        // basic injection and one-cycle latency
        noc.pe_out_ready = 1'b1;
        set_dest(1'b1, 1'b0);
        send_word(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        check("lat_valid", 64'(noc.pe_out_valid), 64'd1);
        check("lat_packet", 64'(noc.pe_out_packet), 64'h2_DEADBEEF);
        step();
        @(negedge clk);
        check("lat_empty", 64'(noc.pe_out_valid), 64'd0);
        step();
        end_packet();

        // fill with backpressure, fifth dropped, head held
        noc.pe_out_ready = 1'b0;
        set_dest(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_word(32'hB000_0000 + 32'(i), 1'b1);
        @(negedge clk);
        check("full_flag", 64'(tx_full), 64'd1);
        check("full_nodrop", 64'(tx_dropped), 64'd0);
        check("hold_head0", 64'(noc.pe_out_packet), 64'(tx_q[0]));
        step();
        send_word(32'hB000_0004, 1'b0);
        @(negedge clk);
        check("full_drop", 64'(tx_dropped), 64'd1);
        check("full_still", 64'(tx_full), 64'd1);
        check("hold_head1", 64'(noc.pe_out_packet), 64'(tx_q[0]));
        step();
        drain_tx();
        @(negedge clk);
        check("drain_valid", 64'(noc.pe_out_valid), 64'd0);
        check("drain_full", 64'(tx_full), 64'd0);
        step();
        end_packet();

        // drops in IDLE, same-cycle coordinate and end-of-packet
        do_reset();
        noc.pe_out_ready = 1'b1;
        send_word(32'h0000_0011, 1'b0);
        @(negedge clk);
        check("idle_drop", 64'(tx_dropped), 64'd1);
        check("idle_valid", 64'(noc.pe_out_valid), 64'd0);
        step();
        set_dest(1'b1, 1'b1);
        end_packet();
        send_word(32'h0000_0022, 1'b0);
        @(negedge clk);
        check("pc_drop_valid", 64'(noc.pe_out_valid), 64'd0);
        step();
        set_dest(1'b1, 1'b1);
        x_coord_in    = 1'b0;
        x_coord_valid = 1'b1;
        send_word(32'h0000_00A1, 1'b1);
        x_coord_valid = 1'b0;
        exp_x = 1'b0;
        send_word(32'h0000_00A2, 1'b1);
        packet_complete = 1'b1;
        send_word(32'h0000_00A3, 1'b1);
        packet_complete = 1'b0;
        send_word(32'h0000_00A4, 1'b0);
        drain_tx();
        @(negedge clk);
        check("pc_end_valid", 64'(noc.pe_out_valid), 64'd0);
        step();

        // reception gated by arming
        do_reset();
        send_rx(32'h0000_0055, 1'b0);
        @(negedge clk);
        check("rx_unarmed_drop", 64'(rx_dropped), 64'd1);
        check("rx_unarmed_avail", 64'(cpu_msg_avail), 64'd0);
        step();
        arm_rx();
        send_rx(32'h0000_0012, 1'b1);
        @(negedge clk);
        check("rx_avail", 64'(cpu_msg_avail), 64'd1);
        check("rx_out", 64'(cpu_msg_out), 64'h12);
        step();
        drain_rx();
        @(negedge clk);
        check("rx_avail_after", 64'(cpu_msg_avail), 64'd0);
        step();

        // RX full with simultaneous push and pop across pointer wrap
        do_reset();
        arm_rx();
        for (int i = 0; i < 4; i++) send_rx(32'hA000_0000 + 32'(i), 1'b1);
        @(negedge clk);
        check("rxf_avail", 64'(cpu_msg_avail), 64'd1);
        step();
        cpu_msg_read = 1'b1;
        for (int i = 4; i < 7; i++) send_rx(32'hA000_0000 + 32'(i), 1'b1);
        cpu_msg_read = 1'b0;
        @(negedge clk);
        check("rxf_nodrop", 64'(rx_dropped), 64'd0);
        step();
        send_rx(32'hA000_00FF, 1'b0);
        @(negedge clk);
        check("rxf_still_full", 64'(rx_dropped), 64'd1);
        step();
        drain_rx();
        @(negedge clk);
        check("rxf_empty", 64'(cpu_msg_avail), 64'd0);
        step();

        // reset with both FIFOs holding words
        arm_rx();
        send_rx(32'h0000_0101, 1'b0);
        send_rx(32'h0000_0102, 1'b0);
        noc.pe_out_ready = 1'b0;
        set_dest(1'b1, 1'b0);
        send_word(32'h0000_0201, 1'b0);
        send_word(32'h0000_0202, 1'b0);
        @(negedge clk);
        check("pre_rst_tx", 64'(noc.pe_out_valid), 64'd1);
        check("pre_rst_rx", 64'(cpu_msg_avail), 64'd1);
        step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        check_zero("mid_rst");
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("post_rst");
        step();
        noc.pe_out_ready = 1'b1;
        set_dest(1'b1, 1'b1);
        send_word(32'hCAFE_0001, 1'b1);
        drain_tx();
        arm_rx();
        send_rx(32'h0000_0034, 1'b1);
        drain_rx();
        @(negedge clk);
        check("final_tx_idle", 64'(noc.pe_out_valid), 64'd0);
        check("final_rx_idle", 64'(cpu_msg_avail), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
